// File: rtl/stream_packetizer.sv
// Stream packetizer: groups every PAYLOAD_LEN input words into a packet led by a
// header beat {HDR_MAGIC, seq}, and flags the final payload beat with o_out_last.
module stream_packetizer #(
  parameter int         WIDTH       = 16,
  parameter int         PAYLOAD_LEN = 8,
  parameter logic [7:0] HDR_MAGIC   = 8'hA5
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last,
  input  logic             i_out_ready,
  output logic [WIDTH-9:0] o_seq,
  output logic             o_dbg_state
);

  // Handshake: a word moves on a rising edge only when valid && ready are both high
  // on that interface; the output beat is held stable while o_out_valid && !i_out_ready.
  localparam int SW = WIDTH - 8;
  localparam int CW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_LEN - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_beat_cnt;
  logic [CW-1:0]    w_beat_cnt_nxt;
  logic [SW-1:0]    r_seq;
  logic [SW-1:0]    w_seq_nxt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic [WIDTH-1:0] w_load_data;
  logic             w_load;
  logic             w_load_last;
  logic             w_slot_free;
  logic             w_in_ready;

  assign w_slot_free = !r_out_valid || i_out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_seq_nxt      = r_seq;
    w_load         = 1'b0;
    w_load_data    = '0;
    w_load_last    = 1'b0;
    w_in_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A header is only started when a payload word is already waiting.
        if (i_enable && i_in_valid && w_slot_free) begin
          w_load         = 1'b1;
          w_load_data    = {HDR_MAGIC, r_seq};
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        w_in_ready = w_slot_free;
        if (i_in_valid && w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = i_in_data;
          w_load_last = (r_beat_cnt == LAST_CNT);
          if (w_load_last) begin
            w_seq_nxt      = r_seq + SW'(1);
            w_beat_cnt_nxt = '0;
            w_state_nxt    = ST_IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_seq      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_seq      <= w_seq_nxt;
    end
  end

  // Output register: a new load may replace a beat being taken in the same cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_load_data;
      r_out_valid <= 1'b1;
      r_out_last  <= w_load_last;
    end else if (w_slot_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_seq       = r_seq;
  assign o_dbg_state = (r_state == ST_PAYLOAD);

endmodule

// File: tb/tb_stream_packetizer.sv
// Bench for stream_packetizer: directed and random streams checked against a
// packet-level model (word count -> header/last/sequence) through expected queues.
module tb_stream_packetizer;

  localparam int LEN_A = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // DUT A: PAYLOAD_LEN = 4
  logic [15:0] a_in_data;
  logic        a_in_valid;
  logic        a_in_ready;
  logic        a_enable;
  logic [15:0] a_out_data;
  logic        a_out_valid;
  logic        a_out_last;
  logic        a_out_ready;
  logic [7:0]  a_seq;
  logic        a_dbg;
  int          rdy_mode;
  logic        man_ready;
  logic        r_rand;

  assign a_out_ready = (rdy_mode == 1) ? r_rand : ((rdy_mode == 2) ? man_ready : 1'b1);

  stream_packetizer #(.WIDTH(16), .PAYLOAD_LEN(LEN_A), .HDR_MAGIC(8'hA5)) u_dut_a (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_in_data(a_in_data), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_enable(a_enable),
    .o_out_data(a_out_data), .o_out_valid(a_out_valid), .o_out_last(a_out_last),
    .i_out_ready(a_out_ready), .o_seq(a_seq), .o_dbg_state(a_dbg)
  );

  // DUT B: PAYLOAD_LEN = 1
  logic [15:0] b_in_data;
  logic        b_in_valid;
  logic        b_in_ready;
  logic        b_enable;
  logic [15:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_last;
  logic        b_out_ready;
  logic [7:0]  b_seq;
  logic        b_dbg;

  stream_packetizer #(.WIDTH(16), .PAYLOAD_LEN(1), .HDR_MAGIC(8'hA5)) u_dut_b (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_in_data(b_in_data), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_enable(b_enable),
    .o_out_data(b_out_data), .o_out_valid(b_out_valid), .o_out_last(b_out_last),
    .i_out_ready(b_out_ready), .o_seq(b_seq), .o_dbg_state(b_dbg)
  );

  // Expected beats as {last, data}
  logic [16:0] exp_q[$];
  logic [16:0] exp_b[$];
  int k_a = 0;
  int k_b = 0;

  logic        rec = 1'b0;
  int          rec_idx = 0;
  logic [10:0] rec_v;
  logic [10:0] rec_r;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: word k of a stream starts a packet when k % LEN == 0 (header first)
  // and ends it when k % LEN == LEN-1; headers count packets modulo 256.
  task automatic send_a(input logic [15:0] d);
    bit ok;
    if (k_a % LEN_A == 0) exp_q.push_back({1'b0, 8'hA5, 8'((k_a / LEN_A) % 256)});
    exp_q.push_back({(k_a % LEN_A == LEN_A - 1), d});
    a_in_valid = 1'b1;
    a_in_data  = d;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (a_in_ready) ok = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL send_a_timeout: word %0h not accepted, required acceptance", d);
    end else begin
      k_a++;
      if (k_a % LEN_A == 0) check("seq_a", a_seq, (k_a / LEN_A) % 256);
    end
  endtask

  task automatic send_b(input logic [15:0] d);
    bit ok;
    exp_b.push_back({1'b0, 8'hA5, 8'(k_b % 256)});
    exp_b.push_back({1'b1, d});
    b_in_valid = 1'b1;
    b_in_data  = d;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (b_in_ready) ok = 1'b1;
      tick();
    end
    b_in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL send_b_timeout: word %0h not accepted, required acceptance", d);
    end else begin
      k_b++;
      check("seq_b", b_seq, k_b % 256);
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 100 && (exp_q.size() != 0 || exp_b.size() != 0); n++) tick();
    check(name, exp_q.size() + exp_b.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    r_rand = ($urandom_range(0, 3) != 0);
  end

  // Monitor A: pops on every output transfer; also checks stall stability.
  initial begin
    logic        prev_stall;
    logic [16:0] prev_beat;
    logic [16:0] e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("hold_a", {a_out_valid, a_out_last, a_out_data}, {1'b1, prev_beat});
        if (a_out_valid && a_out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL beat_a: got unexpected %0h, required no beat", {a_out_last, a_out_data});
          end else begin
            e = exp_q.pop_front();
            check("beat_a", {a_out_last, a_out_data}, e);
          end
        end
        prev_stall = a_out_valid && !a_out_ready;
        prev_beat  = {a_out_last, a_out_data};
      end
    end
  end

  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && b_out_valid && b_out_ready) begin
        if (exp_b.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL beat_b: got unexpected %0h, required no beat", {b_out_last, b_out_data});
        end else begin
          e = exp_b.pop_front();
          check("beat_b", {b_out_last, b_out_data}, e);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rec && rec_idx < 11) begin
      rec_v[rec_idx] = a_out_valid;
      rec_r[rec_idx] = a_in_ready;
      rec_idx++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    rdy_mode = 0;
    man_ready = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_enable = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_enable = 1'b1; b_out_ready = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {a_out_valid, a_out_last, a_in_ready, a_dbg, a_out_data}, 0);
    check("reset_seq", a_seq, 0);
    rst_n = 1'b1;
    tick();

    // Continuous stream: 10 consecutive output beats, ready low only on header slots
    rec = 1'b1;
    for (int i = 1; i <= 8; i++) send_a(16'(i));
    tick();
    tick();
    check("burst_valid", rec_v, 11'b111_1111_1110);
    check("burst_ready", rec_r[9:0], 10'b11110_11110);
    rec = 1'b0;

    // Output stall while payload word 2 is presented
    rdy_mode = 2;
    send_a(16'h0021);
    send_a(16'h0022);
    man_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall", {a_out_valid, a_in_ready, a_out_data}, {1'b1, 1'b0, 16'h0022});
      tick();
    end
    man_ready = 1'b1;
    send_a(16'h0023);
    send_a(16'h0024);
    rdy_mode = 0;

    // Enable dropped mid-packet: packet completes, then no header while disabled
    send_a(16'h0031);
    send_a(16'h0032);
    a_enable = 1'b0;
    send_a(16'h0033);
    send_a(16'h0034);
    a_in_valid = 1'b1;
    a_in_data  = 16'h0035;
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("disabled", {a_out_valid, a_in_ready}, 0);
      tick();
    end
    a_enable = 1'b1;
    for (int i = 5; i <= 8; i++) send_a(16'h0030 + 16'(i));

    // Random traffic until the sequence number has wrapped past 255
    rdy_mode = 1;
    while (k_a < 257 * LEN_A) begin
      repeat ($urandom_range(0, 2)) tick();
      send_a(16'($urandom_range(0, 65535)));
    end
    rdy_mode = 0;
    drain("drain_wrap");

    // Asynchronous reset in the middle of a packet
    send_a(16'h0041);
    send_a(16'h0042);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {a_out_valid, a_out_last, a_in_ready, a_out_data}, 0);
    check("async_rst_seq", a_seq, 0);
    exp_q.delete();
    k_a = 0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) send_a(16'h0050 + 16'(i));
    drain("drain_after_rst");

    // Single-word packets
    send_b(16'h0007);
    send_b(16'h0009);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_b(16'($urandom_range(0, 65535)));
    end
    drain("drain_b");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_packetizer.md
Name: stream_packetizer

Overview:
- Downstream stage of the valid/ready skid buffer; consumes its output stream.
- Groups every PAYLOAD_LEN input words into a packet.
- Prepends a header beat carrying a magic byte and a wrapping sequence number.
- Flags the final payload beat with o_out_last.
- Fully registered output; sustains one beat per cycle under continuous ready.

Parameters:
WIDTH, 16, data width in bits; must be >= 16
PAYLOAD_LEN, 8, payload words per packet; must be >= 1
HDR_MAGIC, 8'hA5, constant placed in header bits [WIDTH-1:WIDTH-8]

Ports:
i_clock  input  1  clock, all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_in_data  input  WIDTH  upstream payload word
i_in_valid  input  1  upstream word valid
o_in_ready  output  1  block accepts i_in_data this cycle
i_enable  input  1  permits start of new packets
o_out_data  output  WIDTH  header or payload word
o_out_valid  output  1  output beat valid
o_out_last  output  1  beat is final payload word of packet
i_out_ready  input  1  downstream accepts output beat
o_seq  output  WIDTH-8  sequence number of next header to be emitted

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (asserted): state=ST_IDLE, beat_cnt=0, seq=0.
- Reset (asserted): o_out_data=0, o_out_valid=0, o_out_last=0, o_in_ready=0 (combinational, forced low by state).
- Takes effect immediately, regardless of clock; a packet in flight is discarded with no partial tail emitted.
- Output slot: slot_free = !o_out_valid || i_out_ready.
- Output slot: while o_out_valid && !i_out_ready, o_out_data and o_out_last hold stable.
- Output slot: when slot_free and nothing is loaded, o_out_valid <= 0 on the next edge.
- Input transfer occurs when i_in_valid && o_in_ready; output transfer occurs when o_out_valid && i_out_ready.
- ST_IDLE: o_in_ready=0.
- ST_IDLE: if i_enable && i_in_valid && slot_free, load header {HDR_MAGIC, seq}, o_out_valid<=1, o_out_last<=0, beat_cnt<=0, state<=ST_PAYLOAD.
- ST_IDLE: otherwise stay. No header is emitted without pending input; empty packets never occur.
- ST_PAYLOAD: o_in_ready = slot_free, combinational, independent of i_in_valid.
- ST_PAYLOAD: on input transfer, load i_in_data, o_out_valid<=1, o_out_last<=(beat_cnt==PAYLOAD_LEN-1).
- ST_PAYLOAD: if that was the last beat, seq<=seq+1 (wraps modulo 2^(WIDTH-8)), beat_cnt<=0, state<=ST_IDLE; else beat_cnt<=beat_cnt+1.
- i_enable is sampled only in ST_IDLE. Deasserting it mid-packet does not truncate; the packet completes, then no new header.
- Latency: input word accepted at edge t appears on o_out_data after edge t (visible cycle t+1).
- Throughput: with i_in_valid and i_out_ready held high, a packet occupies exactly PAYLOAD_LEN+1 consecutive output cycles.
- Throughput: the one-cycle input stall per packet is the header slot.
- Simultaneous events: an output transfer and a new load in the same cycle are legal; the new beat replaces the old with no bubble.
- PAYLOAD_LEN=1: header, then a single beat with o_out_last=1.
- o_seq reflects the seq register directly.

Test Plan:
- WIDTH=16, PAYLOAD_LEN=4, continuous valid/ready, inputs 1,2,3,4,5,6,7,8 -> outputs A500,1,2,3,4(last),A501,5,6,7,8(last); 10 consecutive valid cycles; o_in_ready low exactly on header cycles.
- Same config, i_out_ready low for 3 cycles while payload word 2 is presented -> o_out_data=2 and o_out_valid=1 held 3 cycles; o_in_ready=0 throughout; no word lost or duplicated.
- Force seq to 255 via 255 completed packets, then one more packet -> header A5FF, next header A500; o_seq wraps 255->0.
- i_enable driven low after payload word 2 of a packet -> words 3,4(last) still emitted; no further header while i_enable=0 even with i_in_valid=1; re-enable -> next header A501.
- Assert i_reset_n=0 asynchronously mid-packet (between clock edges) -> o_out_valid, o_out_last, o_out_data, o_in_ready drop to 0 before the next edge; after release the first output is header A500.
- PAYLOAD_LEN=1, inputs 7,9 -> A500,7(last),A501,9(last).
